// File: rtl/perceptron_pkg.sv
// perceptron_pkg
//   Shared types and helpers for the perceptron layer sequencer.
//   - layer_state_t : sequencer state encoding
//   - DATA_W_DEF    : default element/accumulator width
//   - RELU_W        : container width used by relu(); callers sign-extend
//                     narrower accumulators into it and truncate the result
//   - relu()        : passes non-negative values, clamps negatives to zero
package perceptron_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RELU_W     = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAD,
    ST_FLUSH,
    ST_WAIT,
    ST_DRAIN
  } layer_state_t;

  function automatic logic [RELU_W-1:0] relu(input logic [RELU_W-1:0] x);
    return x[RELU_W-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/layer_result_buf.sv
// layer_result_buf
//   N_SLOTS x DATA_W result register file with a per-slot valid mask and a
//   sequential read pointer used while draining results.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             clear valid mask and rewind read pointer
//   wr_en[k]        write wr_data slot k into slot k and set valid[k]
//   wr_data         packed slot data, slot k at [k*DATA_W +: DATA_W]
//   valid           current valid mask
//   rd_adv          step read pointer (wraps after the last slot)
//   rd_data         slot addressed by the read pointer
//   rd_last         read pointer is on the last slot
module layer_result_buf #(
  parameter int N_SLOTS = 4,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic [N_SLOTS-1:0]          wr_en,
  input  logic [N_SLOTS*DATA_W-1:0]   wr_data,
  output logic [N_SLOTS-1:0]          valid,
  input  logic                        rd_adv,
  output logic [DATA_W-1:0]           rd_data,
  output logic                        rd_last
);

  localparam int PTR_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_SLOTS - 1);

  logic [DATA_W-1:0]  slot_q [N_SLOTS];
  logic [DATA_W-1:0]  slot_d [N_SLOTS];
  logic [N_SLOTS-1:0] valid_q, valid_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

  always_comb begin
    slot_d   = slot_q;
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      valid_d  = '0;
      rd_ptr_d = '0;
    end
    for (int k = 0; k < N_SLOTS; k++) begin
      if (wr_en[k]) begin
        slot_d[k]  = wr_data[k*DATA_W +: DATA_W];
        valid_d[k] = 1'b1;
      end
    end
    if (rd_adv) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_SLOTS; k++) slot_q[k] <= '0;
      valid_q  <= '0;
      rd_ptr_q <= '0;
    end else begin
      slot_q   <= slot_d;
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign valid   = valid_q;
  assign rd_data = slot_q[rd_ptr_q];
  assign rd_last = (rd_ptr_q == LAST_PTR);

endmodule

// File: rtl/perceptron_layer_ctrl.sv
// perceptron_layer_ctrl
//   Sequences one fully-connected layer of N_NEURONS perceptrons: broadcasts
//   an input vector to all neurons, collects their accumulators (ReLU applied)
//   and streams the results out in neuron order.
// Ports:
//   s_axi_aclk, s_axi_aresetn         clock, asynchronous active-low reset
//   in_tdata/tvalid/tready/tlast      input vector stream
//   pe_x_tdata/pe_x_tvalid            element broadcast to all neurons
//   pe_start                          held for the whole vector until WAIT exits
//   pe_done, pe_acc                   per-neuron done and packed accumulators
//   out_tdata/tvalid/tready/tlast     result stream
//   busy                              not idle
//   len_err, timeout_err              sticky error flags
//
// state | meaning
// IDLE  | clear counters and mask, wait for first input beat
// RUN   | accept and broadcast input beats
// PAD   | vector ended early, broadcast zeros up to VEC_LEN
// FLUSH | vector too long, swallow beats up to tlast
// WAIT  | collect neuron done pulses, bounded by the timeout
// DRAIN | stream results in neuron order
module perceptron_layer_ctrl
  import perceptron_pkg::*;
#(
  parameter int N_NEURONS    = 4,
  parameter int VEC_LEN      = 784,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic [DATA_W-1:0]             in_tdata,
  input  logic                          in_tvalid,
  output logic                          in_tready,
  input  logic                          in_tlast,
  output logic [DATA_W-1:0]             pe_x_tdata,
  output logic                          pe_x_tvalid,
  output logic                          pe_start,
  input  logic [N_NEURONS-1:0]          pe_done,
  input  logic [N_NEURONS*DATA_W-1:0]   pe_acc,
  output logic [DATA_W-1:0]             out_tdata,
  output logic                          out_tvalid,
  input  logic                          out_tready,
  output logic                          out_tlast,
  output logic                          busy,
  output logic                          len_err,
  output logic                          timeout_err
);

  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int TMR_W = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DONE_TIMEOUT - 1);

  layer_state_t         state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [DATA_W-1:0]    x_data_q, x_data_d;
  logic                 x_valid_q, x_valid_d;
  logic                 len_err_q, len_err_d;
  logic                 timeout_err_q, timeout_err_d;

  logic [N_NEURONS-1:0]        mask, buf_wr_en;
  logic [N_NEURONS*DATA_W-1:0] buf_wr_data;
  logic                        buf_clr, rd_adv, rd_last;
  logic [DATA_W-1:0]           rd_data;
  logic                        capture_en, timed_out;
  logic [RELU_W-1:0]           acc_ext;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmr_d         = TMR_LOAD;
    x_valid_d     = 1'b0;
    x_data_d      = x_data_q;
    len_err_d     = len_err_q;
    timeout_err_d = timeout_err_q;
    in_tready     = 1'b0;
    pe_start      = 1'b0;
    capture_en    = 1'b0;
    buf_clr       = 1'b0;
    timed_out     = 1'b0;
    out_tvalid    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        buf_clr = 1'b1;
        cnt_d   = '0;
        if (in_tvalid) state_d = ST_RUN;
      end
      ST_RUN: begin
        in_tready  = 1'b1;
        pe_start   = 1'b1;
        capture_en = 1'b1;
        if (in_tvalid) begin
          x_valid_d = 1'b1;
          x_data_d  = in_tdata;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            if (in_tlast) begin
              state_d = ST_WAIT;
            end else begin
              len_err_d = 1'b1;
              state_d   = ST_FLUSH;
            end
          end else if (in_tlast) begin
            len_err_d = 1'b1;
            state_d   = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        pe_start   = 1'b1;
        capture_en = 1'b1;
        x_valid_d  = 1'b1;
        x_data_d   = '0;
        cnt_d      = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_IDX) state_d = ST_WAIT;
      end
      ST_FLUSH: begin
        in_tready  = 1'b1;
        pe_start   = 1'b1;
        capture_en = 1'b1;
        if (in_tvalid && in_tlast) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        pe_start   = 1'b1;
        capture_en = 1'b1;
        tmr_d      = tmr_q - TMR_W'(1);
        if (&mask) begin
          state_d = ST_DRAIN;
        end else if (tmr_q == '0) begin
          timed_out     = 1'b1;
          timeout_err_d = 1'b1;
          state_d       = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        out_tvalid = 1'b1;
        if (out_tready && rd_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A done seen in the same cycle as the timeout still wins its slot; only
  // slots with no result at all are zero-filled.
  always_comb begin
    buf_wr_en   = '0;
    buf_wr_data = '0;
    acc_ext     = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      acc_ext = {{(RELU_W-DATA_W){pe_acc[k*DATA_W+DATA_W-1]}}, pe_acc[k*DATA_W +: DATA_W]};
      if (capture_en && pe_done[k] && !mask[k]) begin
        buf_wr_en[k]                       = 1'b1;
        buf_wr_data[k*DATA_W +: DATA_W]    = DATA_W'(relu(acc_ext));
      end else if (timed_out && !mask[k]) begin
        buf_wr_en[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      tmr_q         <= TMR_LOAD;
      x_data_q      <= '0;
      x_valid_q     <= 1'b0;
      len_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      x_data_q      <= x_data_d;
      x_valid_q     <= x_valid_d;
      len_err_q     <= len_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  layer_result_buf #(
    .N_SLOTS (N_NEURONS),
    .DATA_W  (DATA_W)
  ) u_buf (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .clr     (buf_clr),
    .wr_en   (buf_wr_en),
    .wr_data (buf_wr_data),
    .valid   (mask),
    .rd_adv  (rd_adv),
    .rd_data (rd_data),
    .rd_last (rd_last)
  );

  assign rd_adv      = out_tvalid && out_tready;
  assign out_tdata   = rd_data;
  assign out_tlast   = out_tvalid && rd_last;
  assign pe_x_tdata  = x_data_q;
  assign pe_x_tvalid = x_valid_q;
  assign busy        = (state_q != ST_IDLE);
  assign len_err     = len_err_q;
  assign timeout_err = timeout_err_q;

endmodule
